// File: rtl/fifo_gray_sync.sv
// fifo_gray_sync: Gray pointer CDC synchronizer; clk/resetn(sync, active-high) in, syn_ptr_in Gray pointer in, syn_ptr_out synced Gray, bin_ptr_out registered binary, ptr_upd change pulse, gray_err sticky multi-bit flag, err_clr (only with SYNC_GRAY_CHECK_EN) clears it
module fifo_gray_sync #(
  parameter int PTR_WIDTH = 6,
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic [PTR_WIDTH:0] syn_ptr_in,
`ifdef SYNC_GRAY_CHECK_EN
  input  logic err_clr,
`endif
  output logic [PTR_WIDTH:0] syn_ptr_out,
  output logic [PTR_WIDTH:0] bin_ptr_out,
  output logic ptr_upd,
  output logic gray_err
);
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("fifo_gray_sync: STAGES must be in 2..4");
  end
  localparam logic [PTR_WIDTH:0] ONE = 1;
  logic [PTR_WIDTH:0] sync_q [STAGES];
  logic [PTR_WIDTH:0] prev_q, bin_q, bin_d, diff;
  logic upd_q;
  assign syn_ptr_out = sync_q[STAGES-1];
  assign bin_ptr_out = bin_q;
  assign ptr_upd = upd_q;
  assign diff = syn_ptr_out ^ prev_q;
  always_comb begin
    bin_d = '0;
    for (int i = 0; i <= PTR_WIDTH; i++) bin_d[i] = ^(syn_ptr_out >> i);
  end
  always_ff @(posedge clk)
    if (resetn) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      bin_q <= '0;
      upd_q <= 1'b0;
    end else begin
      sync_q[0] <= syn_ptr_in;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= syn_ptr_out;
      bin_q <= bin_d;
      upd_q <= |diff;
    end
`ifdef SYNC_GRAY_CHECK_EN
  logic err_q;
  assign gray_err = err_q;
  always_ff @(posedge clk)
    if (resetn) err_q <= 1'b0;
    else err_q <= (|(diff & (diff - ONE))) | (err_q & ~err_clr);
`else
  logic unused_one;
  assign unused_one = ^ONE;
  assign gray_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_gray_sync.sv
// tb_fifo_gray_sync: directed bench for fifo_gray_sync (STAGES=2 and STAGES=4 instances)
module tb_fifo_gray_sync;
  logic clk = 1'b0;
  always #5 clk = ~clk;
`ifdef SYNC_GRAY_CHECK_EN
  localparam logic CHK = 1'b1;
  logic a_clr = 1'b0;
`else
  localparam logic CHK = 1'b0;
`endif
  logic a_rst, b_rst, a_upd, b_upd, a_err, b_err;
  logic [6:0] a_in, b_in, a_syn, b_syn, a_bin, b_bin;
  int checks = 0, errors = 0, pulses, err_seen;
  fifo_gray_sync #(.PTR_WIDTH(6), .STAGES(2)) u_a (
    .clk(clk), .resetn(a_rst), .syn_ptr_in(a_in),
`ifdef SYNC_GRAY_CHECK_EN
    .err_clr(a_clr),
`endif
    .syn_ptr_out(a_syn), .bin_ptr_out(a_bin), .ptr_upd(a_upd), .gray_err(a_err));
  fifo_gray_sync #(.PTR_WIDTH(6), .STAGES(4)) u_b (
    .clk(clk), .resetn(b_rst), .syn_ptr_in(b_in),
`ifdef SYNC_GRAY_CHECK_EN
    .err_clr(1'b0),
`endif
    .syn_ptr_out(b_syn), .bin_ptr_out(b_bin), .ptr_upd(b_upd), .gray_err(b_err));
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    a_rst = 1'b1; b_rst = 1'b1; a_in = '0; b_in = '0;
    tick; tick;
    check("rst_syn", 32'(a_syn), 0);
    check("rst_bin", 32'(a_bin), 0);
    check("rst_upd", 32'(a_upd), 0);
    check("rst_err", 32'(a_err), 0);
    a_rst = 1'b0; a_in = 7'd1;
    tick;
    check("s1_e1_syn", 32'(a_syn), 0);
    check("s1_e1_upd", 32'(a_upd), 0);
    tick;
    check("s1_e2_syn", 32'(a_syn), 1);
    check("s1_e2_bin", 32'(a_bin), 0);
    tick;
    check("s1_e3_bin", 32'(a_bin), 1);
    check("s1_e3_upd", 32'(a_upd), 1);
    tick;
    check("s1_e4_upd", 32'(a_upd), 0);
    a_in = 7'd0;
    repeat (4) tick;
    check("s2_start_bin", 32'(a_bin), 0);
    pulses = 0; err_seen = 0;
    for (int k = 1; k <= 128; k++) begin
      logic [6:0] b;
      b = 7'(k);
      a_in = b ^ (b >> 1);
      for (int c = 0; c < 4; c++) begin
        tick;
        pulses += int'(a_upd);
        err_seen += int'(a_err);
      end
      check("s2_bin", 32'(a_bin), 32'(k % 128));
    end
    check("s2_pulses", 32'(pulses), 128);
    check("s2_err", 32'(err_seen), 0);
    a_in = 7'b0000011;
    tick; tick;
    check("s3_syn", 32'(a_syn), 3);
    check("s3_err_pre", 32'(a_err), 0);
    tick;
    check("s3_bin", 32'(a_bin), 2);
    check("s3_upd", 32'(a_upd), 1);
    check("s3_err", 32'(a_err), 32'(CHK));
    repeat (10) tick;
    check("s3_err_hold", 32'(a_err), 32'(CHK));
    check("s3_upd_low", 32'(a_upd), 0);
`ifdef SYNC_GRAY_CHECK_EN
    a_clr = 1'b1;
`endif
    tick;
    check("s3_err_clr", 32'(a_err), 0);
    a_in = 7'b0000000;
    tick; tick; tick;
    check("s4_err_set_wins", 32'(a_err), 32'(CHK));
    check("s4_bin", 32'(a_bin), 0);
    check("s4_upd", 32'(a_upd), 1);
    tick;
    check("s4_err_after", 32'(a_err), 0);
    check("s4_upd_after", 32'(a_upd), 0);
`ifdef SYNC_GRAY_CHECK_EN
    a_clr = 1'b0;
`endif
    b_rst = 1'b0; b_in = 7'b1000000;
    tick;
    b_rst = 1'b1;
    tick;
    check("s5_rst_syn", 32'(b_syn), 0);
    check("s5_rst_bin", 32'(b_bin), 0);
    check("s5_rst_upd", 32'(b_upd), 0);
    check("s5_rst_err", 32'(b_err), 0);
    b_rst = 1'b0;
    tick; tick; tick;
    check("s5_e3_syn", 32'(b_syn), 0);
    check("s5_e3_upd", 32'(b_upd), 0);
    tick;
    check("s5_e4_syn", 32'(b_syn), 64);
    check("s5_e4_bin", 32'(b_bin), 0);
    tick;
    check("s5_e5_bin", 32'(b_bin), 127);
    check("s5_e5_upd", 32'(b_upd), 1);
    tick;
    check("s5_e6_upd", 32'(b_upd), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_gray_sync.md
FIFO_GRAY_SYNC -- requirements
Module: fifo_gray_sync

Interface
REQ-001 The block SHALL have parameter PTR_WIDTH, default 6, meaning FIFO address bits; pointer width is PTR_WIDTH+1 (wrap bit included).
REQ-002 The block SHALL have parameter STAGES, default 2, meaning synchronizer flop count; legal range 2..4; any other value SHALL be a static elaboration error.
REQ-003 The block SHALL have port clk, input, 1 bit: destination-domain clock; the block has one clock only.
REQ-004 The block SHALL have port resetn, input, 1 bit: synchronous, active-high reset; resetn=1 at a clk rising edge resets the block.
REQ-005 The block SHALL have port syn_ptr_in, input, PTR_WIDTH+1 bits: Gray-coded pointer from the source domain, asynchronous to clk.
REQ-006 The block SHALL have port syn_ptr_out, output, PTR_WIDTH+1 bits: synchronized Gray pointer.
REQ-007 The block SHALL have port bin_ptr_out, output, PTR_WIDTH+1 bits: registered binary equivalent of syn_ptr_out.
REQ-008 The block SHALL have port ptr_upd, output, 1 bit: single-cycle pulse, high when bin_ptr_out takes a new value.
REQ-009 The block SHALL have port err_clr, input, 1 bit: clears gray_err; present only with SYNC_GRAY_CHECK_EN.
REQ-010 The block SHALL have port gray_err, output, 1 bit: sticky multi-bit-change flag; present in both builds.

Function
REQ-011 Synchronizer SHALL be a chain of STAGES registers, every stage full PTR_WIDTH+1 bits wide; stage 0 samples syn_ptr_in, and each later stage samples its predecessor.
REQ-012 syn_ptr_out SHALL equal the last stage; latency from a stable syn_ptr_in to syn_ptr_out is exactly STAGES clk edges.
REQ-013 The block SHALL hold a previous-value register prev_gray <= syn_ptr_out every cycle.
REQ-014 bin_ptr_out SHALL be registered Gray-to-binary of syn_ptr_out: bit MSB = g[MSB]; bit i = b[i+1] XOR g[i]; latency STAGES+1 edges from syn_ptr_in.
REQ-015 ptr_upd SHALL be registered (syn_ptr_out != prev_gray), aligned with the cycle in which bin_ptr_out first shows the new value; it SHALL be high one cycle per distinct change.
REQ-016 Wrap-around: a Gray change from the all-ones binary code to 0 SHALL be treated as an ordinary single-bit change: bin_ptr_out goes 2^(PTR_WIDTH+1)-1 -> 0, ptr_upd pulses, and no error.
REQ-017 When syn_ptr_out changes on consecutive cycles, ptr_upd SHALL stay high on each of those cycles; there SHALL be no gaps and no merging.
REQ-018 The synchronizer stages SHALL contain no combinational logic between them.

Reset
REQ-019 On reset, all synchronizer stages, prev_gray, bin_ptr_out, syn_ptr_out, ptr_upd and gray_err SHALL be 0 at the following edge.
REQ-020 A reset asserted mid-transfer SHALL discard in-flight values.
REQ-021 On the first edge after reset deasserts, stage 0 SHALL sample syn_ptr_in.
REQ-022 ptr_upd SHALL NOT pulse due to reset itself.
REQ-023 The first post-reset update of a nonzero pointer SHALL pulse ptr_upd normally.

Configuration
REQ-024 Macro SYNC_GRAY_CHECK_EN defined: the block SHALL set gray_err when popcount(syn_ptr_out XOR prev_gray) > 1, registered, one cycle after the offending syn_ptr_out.
REQ-025 With SYNC_GRAY_CHECK_EN defined, gray_err SHALL stay high until an edge with err_clr=1 or reset.
REQ-026 With SYNC_GRAY_CHECK_EN defined, if a set condition and err_clr=1 occur in the same cycle, the set SHALL win.
REQ-027 Macro SYNC_GRAY_CHECK_EN undefined: the checker logic and the err_clr port SHALL be absent.
REQ-028 Macro SYNC_GRAY_CHECK_EN undefined: gray_err SHALL be tied 0.
REQ-029 Macro SYNC_GRAY_CHECK_EN undefined: all other behaviour SHALL be identical to the defined build.

Verification (PTR_WIDTH=6, STAGES=2 unless stated)
REQ-030 Scenario 1: reset, then syn_ptr_in 0 -> 7'b0000001 held -> syn_ptr_out=1 after 2 edges; bin_ptr_out=1 and ptr_upd=1 for exactly one cycle after edge 3.
REQ-031 Scenario 2: syn_ptr_in stepped through Gray codes of binary 0..127 then 0, one step per 4 clk -> bin_ptr_out follows 0..127,0 with 128 ptr_upd pulses and gray_err=0 throughout.
REQ-032 Scenario 3: SYNC_GRAY_CHECK_EN defined, syn_ptr_in 0 -> 7'b0000011 -> gray_err=1 one edge after syn_ptr_out=3 and held 10 cycles; err_clr pulse clears it at the next edge.
REQ-033 Scenario 4: the same two-bit jump with err_clr held 1 -> gray_err=1 for the setting cycle (set wins), then 0.
REQ-034 Scenario 5: STAGES=4, syn_ptr_in=7'b1000000 held; resetn pulsed at edge 2 -> all outputs 0; syn_ptr_out=7'b1000000 exactly 4 edges after reset release, and bin_ptr_out=127 one edge later.
REQ-035 Scenario 6: SYNC_GRAY_CHECK_EN undefined, two-bit jump -> gray_err stays 0; bin_ptr_out and ptr_upd are identical to the defined build.
